// File: rtl/output_drain_buffer.sv
// ============================================================================
// output_drain_buffer: circular FIFO absorbing accelerator beats, drained over valid/ready.
// Optional macro OUTPUT_BEAT_COUNT_EN adds beat_count. Revision 1.0
// ============================================================================
`default_nettype none

module output_drain_buffer #(
  parameter int MEM_BW = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MEM_BW-1:0]        acc_data,
  input  logic                     acc_valid,
  input  logic                     acc_running,
  output logic [MEM_BW-1:0]        mem_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
`ifdef OUTPUT_BEAT_COUNT_EN
  output logic [31:0]              beat_count,
`endif
  output logic                     layer_done
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MEM_BW-1:0]    mem_q [DEPTH];
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 w_full, w_pop, w_push;

  assign w_full = (count_q == c_FULL);
  assign w_pop  = (count_q != '0) && mem_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign w_push = acc_valid && (!w_full || w_pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (acc_valid & w_full & ~w_pop);
    if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_running) state_d = RUN;
      RUN:     if (!acc_running) state_d = DRAIN;
      DRAIN: begin
        if (acc_running)                        state_d = RUN;
        else if ((count_q == '0) && !w_push)    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: mem_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[wr_ptr_q] <= acc_data;
  end

`ifdef OUTPUT_BEAT_COUNT_EN
  logic [31:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if ((state_q == IDLE) && (state_d == RUN)) beat_count_d = w_pop ? 32'd1 : 32'd0;
    else if (w_pop)                            beat_count_d = beat_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) beat_count_q <= '0;
    else     beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;
`endif

  assign mem_valid  = (count_q != '0);
  assign mem_data   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fill_level = count_q;
  assign overflow   = overflow_q;
  assign layer_done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_output_drain_buffer.sv
// ============================================================================
// tb_output_drain_buffer: directed self-checking bench for output_drain_buffer. Revision 1.0
// ============================================================================
`default_nettype none

module tb_output_drain_buffer;

  localparam int MEM_BW = 128;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic [MEM_BW-1:0] acc_data;
  logic              acc_valid;
  logic              acc_running;
  logic [MEM_BW-1:0] mem_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [4:0]        fill_level;
  logic              overflow;
  logic              layer_done;
`ifdef OUTPUT_BEAT_COUNT_EN
  logic [31:0]       beat_count;
`endif

  int checks = 0;
  int errors = 0;

  output_drain_buffer #(.MEM_BW(MEM_BW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .acc_data    (acc_data),
    .acc_valid   (acc_valid),
    .acc_running (acc_running),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .fill_level  (fill_level),
    .overflow    (overflow),
`ifdef OUTPUT_BEAT_COUNT_EN
    .beat_count  (beat_count),
`endif
    .layer_done  (layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [MEM_BW-1:0] obs, input logic [MEM_BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; acc_data = '0; acc_valid = 1'b0; acc_running = 1'b0; mem_ready = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_mem_valid",  128'(mem_valid),  128'd0);
    check("rst_mem_data",   mem_data,         128'd0);
    check("rst_fill",       128'(fill_level), 128'd0);
    check("rst_overflow",   128'(overflow),   128'd0);
    check("rst_layer_done", 128'(layer_done), 128'd0);
`ifdef OUTPUT_BEAT_COUNT_EN
    check("rst_beat_count", 128'(beat_count), 128'd0);
`endif

    // Streaming with sink always ready: one-cycle latency, level never above 1
    mem_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      acc_valid = 1'b1; acc_data = 128'(i);
      tick();
      check("stream_valid", 128'(mem_valid),  128'd1);
      check("stream_data",  mem_data,         128'(i));
      check("stream_fill",  128'(fill_level), 128'd1);
    end
    acc_valid = 1'b0;
    tick();
    check("stream_empty_valid", 128'(mem_valid),  128'd0);
    check("stream_empty_fill",  128'(fill_level), 128'd0);
    check("stream_empty_data",  mem_data,         128'd0);

    // Fill with sink stalled; 17th beat must be dropped
    mem_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      acc_valid = 1'b1; acc_data = 128'h100 + 128'(i);
      tick();
      if (i == 16) check("fill16_overflow", 128'(overflow), 128'd0);
    end
    acc_valid = 1'b0;
    check("full_fill",     128'(fill_level), 128'd16);
    check("full_overflow", 128'(overflow),   128'd1);
    tick();
    check("stall_head_stable", mem_data,     128'h101);
    mem_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("drain_data", mem_data, 128'h100 + 128'(k));
      tick();
    end
    check("drain_fill",      128'(fill_level), 128'd0);
    check("drain_valid",     128'(mem_valid),  128'd0);
    check("overflow_sticky", 128'(overflow),   128'd1);
    check("no_done_idle",    128'(layer_done), 128'd0);

    rst = 1'b1; mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("ovf_cleared", 128'(overflow), 128'd0);

    // Full FIFO with simultaneous pop and push
    for (int i = 1; i <= 16; i++) begin
      acc_valid = 1'b1; acc_data = 128'h200 + 128'(i);
      tick();
    end
    check("full2_fill", 128'(fill_level), 128'd16);
    mem_ready = 1'b1; acc_valid = 1'b1; acc_data = 128'h2FF;
    tick();
    acc_valid = 1'b0;
    check("fullpp_fill",     128'(fill_level), 128'd16);
    check("fullpp_overflow", 128'(overflow),   128'd0);
    for (int k = 2; k <= 16; k++) begin
      check("fullpp_data", mem_data, 128'h200 + 128'(k));
      tick();
    end
    check("fullpp_last", mem_data, 128'h2FF);
    tick();
    check("fullpp_empty", 128'(fill_level), 128'd0);

    // Layer run: 10 running cycles, 8 pushes, sink ready on odd cycles.
    // Final pop lands at the edge ending cycle 15; DONE is visible after edge 16.
    for (int c = 0; c <= 18; c++) begin
      acc_running = (c < 10);
      acc_valid   = (c < 8);
      acc_data    = 128'h300 + 128'(c);
      mem_ready   = c[0];
      tick();
      check("layer_done_pulse", 128'(layer_done), (c == 16) ? 128'd1 : 128'd0);
      if (c == 9)  check("run_fill_c9",   128'(fill_level), 128'd3);
      if (c == 15) check("run_fill_c15",  128'(fill_level), 128'd0);
`ifdef OUTPUT_BEAT_COUNT_EN
      if (c == 16) check("run_beat_count", 128'(beat_count), 128'd8);
`endif
    end
    acc_valid = 1'b0; mem_ready = 1'b0;

    // Reset mid-transfer discards buffered beats without a layer_done
    for (int i = 1; i <= 7; i++) begin
      acc_running = 1'b1; acc_valid = 1'b1; acc_data = 128'h400 + 128'(i);
      tick();
    end
    acc_valid = 1'b0;
    check("pre_rst_fill", 128'(fill_level), 128'd7);
    rst = 1'b1; acc_running = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_valid", 128'(mem_valid),  128'd0);
    check("midrst_fill",  128'(fill_level), 128'd0);
    check("midrst_done",  128'(layer_done), 128'd0);
`ifdef OUTPUT_BEAT_COUNT_EN
    check("midrst_beat_count", 128'(beat_count), 128'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", 128'(layer_done), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
